pmp_ctrl: RTL and testbench

PMP_CTRL -- requirements
Module: pmp_ctrl

---
 rtl/pmp_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_pmp_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_ctrl.sv
// pmp_ctrl -- physical memory protection checker with a CSR file and
// NUM_PORT independent single-stage check pipelines.
//
// Parameters
//   PMP_ENTRY  number of implemented entries (1..16)
//   NUM_PORT   number of check ports (port 0 fetch, port 1 load/store)
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   csr_we_i/addr/wdata   CSR write (pmpcfg0..3 @0x3A0, pmpaddr0..15 @0x3B0)
//   csr_rdata_o           combinational read of csr_addr_i
//   priv_i                per port: 1 = M-mode, 0 = U-mode
//   chk_valid_i/ready_o   request handshake, chk_addr_i, chk_type_i ([X,W,R])
//   rsp_valid_o/ready_i   response handshake, rsp_err_o = access fault
//   err_valid_o/addr_o    first-fault capture, err_clr_i clears it
//
// Build option
//   PMP_ERR_CAPTURE_EN    enables the fault capture; when undefined the
//                         capture outputs are tied to 0 and err_clr_i is unused.

// Per-port checker: priority match over all entries plus the response register.
module pmp_port #(
  parameter int PMP_ENTRY = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PMP_ENTRY-1:0][7:0]  cfg,
  input  logic [PMP_ENTRY-1:0][31:0] pmpaddr,
  input  logic                       priv,
  input  logic                       chk_valid,
  output logic                       chk_ready,
  input  logic [31:0]                chk_addr,
  input  logic [2:0]                 chk_type,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_err,
  output logic                       fault_acc
);
  logic [33:0]          a;
  logic [PMP_ENTRY-1:0] hit;
  logic                 sel_hit, sel_l;
  logic [2:0]           sel_xwr;
  logic                 one_hot, perm, fault, accept;

  assign a = {2'b00, chk_addr};

  genvar i;
  for (i = 0; i < PMP_ENTRY; i++) begin : g_ent
    logic [31:0] lo, care;
    logic        tor, na4, napot;
    logic        unused_rsvd;
    if (i == 0) begin : g_lo0
      assign lo = '0;
    end else begin : g_lon
      assign lo = pmpaddr[i-1];
    end
    // p ^ (p+1) sets the trailing-ones run plus the first zero: those bits
    // are don't-care inside the NAPOT region.
    assign care  = ~(pmpaddr[i] ^ (pmpaddr[i] + 32'd1));
    assign tor   = (a >= {lo, 2'b00}) && (a < {pmpaddr[i], 2'b00});
    assign na4   = (a[33:2] == pmpaddr[i]);
    assign napot = ((a[33:2] ^ pmpaddr[i]) & care) == '0;
    assign hit[i] = (cfg[i][4:3] == 2'd1) ? tor :
                    (cfg[i][4:3] == 2'd2) ? na4 :
                    (cfg[i][4:3] == 2'd3) ? napot : 1'b0;
    assign unused_rsvd = ^cfg[i][6:5];
  end

  // Walk from the top down so the lowest matching entry ends up selected.
  always_comb begin
    sel_hit = 1'b0;
    sel_l   = 1'b0;
    sel_xwr = 3'b000;
    for (int k = PMP_ENTRY-1; k >= 0; k--) begin
      if (hit[k]) begin
        sel_hit = 1'b1;
        sel_l   = cfg[k][7];
        sel_xwr = cfg[k][2:0];
      end
    end
  end

  assign one_hot = (chk_type == 3'b001) || (chk_type == 3'b010) || (chk_type == 3'b100);
  assign perm    = |(chk_type & sel_xwr);

  always_comb begin
    fault = 1'b0;
    if (!one_hot)          fault = 1'b1;
    else if (sel_hit)      fault = (priv && !sel_l) ? 1'b0 : !perm;
    else                   fault = !priv;
  end

  assign chk_ready = ~rsp_valid | rsp_ready;
  assign accept    = chk_valid & chk_ready;
  assign fault_acc = accept & fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= fault;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

module pmp_ctrl #(
  parameter int PMP_ENTRY = 16,
  parameter int NUM_PORT  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     csr_we_i,
  input  logic [11:0]              csr_addr_i,
  input  logic [31:0]              csr_wdata_i,
  output logic [31:0]              csr_rdata_o,
  input  logic [NUM_PORT-1:0]      priv_i,
  input  logic [NUM_PORT-1:0]      chk_valid_i,
  output logic [NUM_PORT-1:0]      chk_ready_o,
  input  logic [NUM_PORT-1:0][31:0] chk_addr_i,
  input  logic [NUM_PORT-1:0][2:0] chk_type_i,
  output logic [NUM_PORT-1:0]      rsp_valid_o,
  input  logic [NUM_PORT-1:0]      rsp_ready_i,
  output logic [NUM_PORT-1:0]      rsp_err_o,
  output logic                     err_valid_o,
  output logic [31:0]              err_addr_o,
  input  logic                     err_clr_i
);
  localparam int CFG_BASE  = 'h3A0;
  localparam int ADDR_BASE = 'h3B0;

  logic [PMP_ENTRY-1:0][7:0]  cfg_q;
  logic [PMP_ENTRY-1:0][31:0] addr_q;
  logic [PMP_ENTRY-1:0]       addr_lock;
  logic [NUM_PORT-1:0]        fault_acc;

  // Reserved bits read as 0; W without R is not a legal combination.
  function automatic logic [7:0] legal_cfg(input logic [7:0] b);
    return {b[7], 2'b00, b[4:3], b[2], b[1] & b[0], b[0]};
  endfunction

  // pmpaddr[i] is frozen by its own lock or by a locked TOR entry above it,
  // since that entry uses pmpaddr[i] as its lower bound.
  genvar g;
  for (g = 0; g < PMP_ENTRY; g++) begin : g_lock
    if (g < PMP_ENTRY-1) begin : g_tor
      assign addr_lock[g] = cfg_q[g][7] | (cfg_q[g+1][7] & (cfg_q[g+1][4:3] == 2'd1));
    end else begin : g_last
      assign addr_lock[g] = cfg_q[g][7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= '0;
      addr_q <= '0;
    end else if (csr_we_i) begin
      for (int i = 0; i < PMP_ENTRY; i++) begin
        if (csr_addr_i == 12'(CFG_BASE + i/4) && !cfg_q[i][7])
          cfg_q[i] <= legal_cfg(csr_wdata_i[(i%4)*8 +: 8]);
        if (csr_addr_i == 12'(ADDR_BASE + i) && !addr_lock[i])
          addr_q[i] <= csr_wdata_i;
      end
    end
  end

  // Unimplemented entries fall through to the zero default.
  always_comb begin
    csr_rdata_o = '0;
    for (int i = 0; i < PMP_ENTRY; i++) begin
      if (csr_addr_i == 12'(CFG_BASE + i/4))
        csr_rdata_o[(i%4)*8 +: 8] = cfg_q[i];
      if (csr_addr_i == 12'(ADDR_BASE + i))
        csr_rdata_o = addr_q[i];
    end
  end

  for (g = 0; g < NUM_PORT; g++) begin : g_port
    pmp_port #(.PMP_ENTRY(PMP_ENTRY)) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg       (cfg_q),
      .pmpaddr   (addr_q),
      .priv      (priv_i[g]),
      .chk_valid (chk_valid_i[g]),
      .chk_ready (chk_ready_o[g]),
      .chk_addr  (chk_addr_i[g]),
      .chk_type  (chk_type_i[g]),
      .rsp_valid (rsp_valid_o[g]),
      .rsp_ready (rsp_ready_i[g]),
      .rsp_err   (rsp_err_o[g]),
      .fault_acc (fault_acc[g])
    );
  end

`ifdef PMP_ERR_CAPTURE_EN
  logic        new_fault;
  logic [31:0] new_addr;

  // Lowest-numbered faulting port wins.
  always_comb begin
    new_fault = 1'b0;
    new_addr  = '0;
    for (int p = NUM_PORT-1; p >= 0; p--) begin
      if (fault_acc[p]) begin
        new_fault = 1'b1;
        new_addr  = chk_addr_i[p];
      end
    end
  end

  // A clear coinciding with a new fault re-arms with the new fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
    end else if (new_fault && (!err_valid_o || err_clr_i)) begin
      err_valid_o <= 1'b1;
      err_addr_o  <= new_addr;
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = ^{err_clr_i, fault_acc};
  assign err_valid_o    = 1'b0;
  assign err_addr_o     = '0;
`endif
endmodule

// File: tb/tb_pmp_ctrl.sv
module tb_pmp_ctrl;
  logic             clk = 1'b0;
  logic             rst_n;
  logic             csr_we;
  logic [11:0]      csr_addr;
  logic [31:0]      csr_wdata, csr_rdata;
  logic [1:0]       priv, chk_valid, chk_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0] chk_addr;
  logic [1:0][2:0]  chk_type;
  logic             err_valid, err_clr;
  logic [31:0]      err_addr;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] R = 3'b001, W = 3'b010, X = 3'b100;

  pmp_ctrl #(.PMP_ENTRY(16), .NUM_PORT(2)) dut (
    .clk(clk), .rst_n(rst_n), .csr_we_i(csr_we), .csr_addr_i(csr_addr),
    .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata), .priv_i(priv),
    .chk_valid_i(chk_valid), .chk_ready_o(chk_ready), .chk_addr_i(chk_addr),
    .chk_type_i(chk_type), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_err_o(rsp_err), .err_valid_o(err_valid), .err_addr_o(err_addr),
    .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    @(posedge clk); #1;
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #1 d = csr_rdata;
  endtask

  // One request on port p with the response side ready; returns {valid,err}
  // sampled just after the accept edge.
  task automatic req(input int p, input logic pv, input logic [31:0] a,
                     input logic [2:0] t, output logic [1:0] ve);
    @(negedge clk);
    rsp_ready = 2'b11; priv[p] = pv; chk_addr[p] = a; chk_type[p] = t;
    chk_valid = 2'b00; chk_valid[p] = 1'b1;
    @(posedge clk); #1;
    ve = {rsp_valid[p], rsp_err[p]};
    chk_valid = 2'b00;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    priv = '0; chk_valid = '0; chk_addr = '0; chk_type = '0;
    rsp_ready = 2'b11; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (rsp_err !== 2'b00) begin failures++; $display("FAIL reset_rsp_err got=%b exp=00", rsp_err); end
    checks++; if (chk_ready !== 2'b11) begin failures++; $display("FAIL reset_chk_ready got=%b exp=11", chk_ready); end
    checks++; if ({err_valid, err_addr} !== 33'd0) begin failures++; $display("FAIL reset_err got=%b/%h exp=0/0", err_valid, err_addr); end
    csr_rd(12'h3A0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_cfg0 got=%h exp=0", d); end
    csr_rd(12'h3B5, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_addr5 got=%h exp=0", d); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  // pmpaddr0=0x400 -> TOR region [0,0x1000); cfg 0x0D = TOR with X and R.
  task automatic test_tor();
    logic [31:0] d;
    logic [1:0]  ve;
    logic [31:0] va[6] = '{32'h0FFC, 32'h0FFC, 32'h1000, 32'h0000, 32'h1000, 32'h0FFC};
    logic [2:0]  ty[6] = '{R, W, R, X, W, W};
    logic        pv[6] = '{0, 0, 0, 0, 1, 1};
    logic        ex[6] = '{0, 1, 1, 0, 0, 0};
    csr_wr(12'h3B0, 32'h400);
    csr_wr(12'h3A0, 32'h0D);
    csr_rd(12'h3A0, d);
    checks++; if (d !== 32'h0D) begin failures++; $display("FAIL tor_cfg_rd got=%h exp=0000000d", d); end
    for (int k = 0; k < 6; k++) begin
      req(k % 2, pv[k], va[k], ty[k], ve);
      checks++;
      if (ve !== {1'b1, ex[k]}) begin
        failures++; $display("FAIL tor_vec%0d got=%b exp=%b", k, ve, {1'b1, ex[k]});
      end
    end
  endtask

  // entry0 NA4 @0x2000 locked no-perm, entry1 NAPOT 0x0..0xFFFF RWX.
  task automatic test_na4_napot();
    logic [31:0] d;
    logic [1:0]  ve;
    logic [31:0] va[6] = '{32'h2000, 32'h2004, 32'hFFFC, 32'h10000, 32'h10000, 32'h2004};
    logic [2:0]  ty[6] = '{R, R, R, R, R, 3'b011};
    logic        pv[6] = '{1, 1, 0, 0, 1, 1};
    logic        ex[6] = '{1, 0, 0, 1, 0, 1};
    csr_wr(12'h3B0, 32'h800);
    csr_wr(12'h3B1, 32'h1FFF);
    csr_wr(12'h3A0, 32'h00001F90);
    for (int k = 0; k < 6; k++) begin
      req(k % 2, pv[k], va[k], ty[k], ve);
      checks++;
      if (ve !== {1'b1, ex[k]}) begin
        failures++; $display("FAIL napot_vec%0d got=%b exp=%b", k, ve, {1'b1, ex[k]});
      end
    end
    // byte0 locked, byte2 W-only dropped to 0, byte3 reserved bits cleared
    csr_wr(12'h3A0, 32'h61021F00);
    csr_rd(12'h3A0, d);
    checks++; if (d !== 32'h01001F90) begin failures++; $display("FAIL cfg_legalize got=%h exp=01001f90", d); end
    req(0, 1'b1, 32'h0, 3'b000, ve);
    checks++; if (ve !== 2'b11) begin failures++; $display("FAIL type_zero got=%b exp=11", ve); end
  endtask

  task automatic test_lock();
    logic [31:0] d;
    logic [11:0] ra[6] = '{12'h3A0, 12'h3B0, 12'h3B1, 12'h3B2, 12'h3B3, 12'h3C0};
    logic [31:0] ex[6] = '{32'h00880080, 32'h55, 32'h66, 32'h0, 32'h99, 32'h0};
    pulse_reset();
    csr_wr(12'h3B0, 32'h55);
    csr_wr(12'h3B1, 32'h66);
    csr_wr(12'h3A0, 32'h00880080);
    csr_wr(12'h3A0, 32'h0);
    csr_wr(12'h3B0, 32'h1234);
    csr_wr(12'h3B1, 32'h77);
    csr_wr(12'h3B2, 32'hAA);
    csr_wr(12'h3B3, 32'h99);
    for (int k = 0; k < 6; k++) begin
      csr_rd(ra[k], d);
      checks++;
      if (d !== ex[k]) begin failures++; $display("FAIL lock_rd_%h got=%h exp=%h", ra[k], d, ex[k]); end
    end
    pulse_reset();
    csr_rd(12'h3A0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL lock_after_reset_cfg got=%h exp=0", d); end
    csr_rd(12'h3B0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL lock_after_reset_addr got=%h exp=0", d); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rsp_ready = 2'b10; priv[0] = 1'b1; chk_addr[0] = 32'h0; chk_type[0] = R; chk_valid = 2'b01;
    @(posedge clk); #1;
    chk_valid = 2'b00;
    checks++; if (rsp_valid[0] !== 1'b1) begin failures++; $display("FAIL mid_pending got=%b exp=1", rsp_valid[0]); end
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL mid_discard got=%b exp=00", rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 2'b11; chk_valid = 2'b01;
    @(posedge clk); #1;
    chk_valid = 2'b00;
    checks++; if ({rsp_valid[0], rsp_err[0]} !== 2'b10) begin failures++; $display("FAIL mid_first_accept got=%b exp=10", {rsp_valid[0], rsp_err[0]}); end
  endtask

  task automatic test_backpressure();
    logic [31:0] va[3] = '{32'h2000, 32'h0200, 32'h0};
    logic [2:0]  ty[3] = '{R, X, R};
    logic        ex[3] = '{1, 1, 0};
    csr_wr(12'h3B0, 32'h400);
    csr_wr(12'h3A0, 32'h0D);
    @(negedge clk);
    rsp_ready[1] = 1'b0; priv[1] = 1'b0; chk_addr[1] = 32'h100; chk_type[1] = R; chk_valid = 2'b10;
    @(posedge clk); #1;
    checks++; if ({rsp_valid[1], rsp_err[1]} !== 2'b10) begin failures++; $display("FAIL bp_first got=%b exp=10", {rsp_valid[1], rsp_err[1]}); end
    chk_type[1] = W;  // next pending request: U write in region -> fault
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({chk_ready[1], rsp_valid[1], rsp_err[1]} !== 3'b010) begin
        failures++; $display("FAIL bp_hold%0d got=%b exp=010", k, {chk_ready[1], rsp_valid[1], rsp_err[1]});
      end
    end
    rsp_ready[1] = 1'b1;
    #1;
    checks++; if (chk_ready[1] !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", chk_ready[1]); end
    // responses B(write, fault), C(read 0x2000, fault), D(exec 0x200, ok)
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid[1], rsp_err[1]} !== {1'b1, ex[k]}) begin
        failures++; $display("FAIL bp_stream%0d got=%b exp=%b", k, {rsp_valid[1], rsp_err[1]}, {1'b1, ex[k]});
      end
      if (k < 2) begin chk_addr[1] = va[k]; chk_type[1] = ty[k]; end
      else chk_valid = 2'b00;
    end
    @(posedge clk); #1;
    checks++; if (rsp_valid[1] !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", rsp_valid[1]); end
  endtask

  task automatic test_csr_same_cycle();
    @(negedge clk);
    csr_we = 1'b1; csr_addr = 12'h3A0; csr_wdata = 32'h08;
    rsp_ready = 2'b11; priv[0] = 1'b0; chk_addr[0] = 32'h100; chk_type[0] = R; chk_valid = 2'b01;
    @(posedge clk); #1;
    csr_we = 1'b0;
    checks++; if ({rsp_valid[0], rsp_err[0]} !== 2'b10) begin failures++; $display("FAIL same_cycle_old got=%b exp=10", {rsp_valid[0], rsp_err[0]}); end
    @(posedge clk); #1;
    chk_valid = 2'b00;
    checks++; if ({rsp_valid[0], rsp_err[0]} !== 2'b11) begin failures++; $display("FAIL same_cycle_new got=%b exp=11", {rsp_valid[0], rsp_err[0]}); end
  endtask

  task automatic test_parallel();
    csr_wr(12'h3A0, 32'h0D);
    @(negedge clk);
    rsp_ready = 2'b11; priv = 2'b00;
    chk_addr[0] = 32'h100; chk_type[0] = X;
    chk_addr[1] = 32'h100; chk_type[1] = W;
    chk_valid = 2'b11;
    @(posedge clk); #1;
    chk_valid = 2'b00;
    checks++; if ({rsp_valid, rsp_err} !== 4'b1110) begin failures++; $display("FAIL parallel got=%b exp=1110", {rsp_valid, rsp_err}); end
  endtask

  task automatic test_err_capture();
    logic [1:0]  ve;
    logic        exp_v;
    logic [31:0] exp_a;
    pulse_reset();
    @(negedge clk);
    rsp_ready = 2'b11; priv = 2'b00;
    chk_addr[0] = 32'h5000; chk_type[0] = R;
    chk_addr[1] = 32'h7000; chk_type[1] = R;
    chk_valid = 2'b11;
    @(posedge clk); #1;
    chk_valid = 2'b00;
`ifdef PMP_ERR_CAPTURE_EN
    exp_v = 1'b1; exp_a = 32'h5000;
`else
    exp_v = 1'b0; exp_a = 32'h0;
`endif
    checks++; if ({err_valid, err_addr} !== {exp_v, exp_a}) begin failures++; $display("FAIL cap_first got=%b/%h exp=%b/%h", err_valid, err_addr, exp_v, exp_a); end
    req(0, 1'b0, 32'h6000, R, ve);
    checks++; if ({err_valid, err_addr} !== {exp_v, exp_a}) begin failures++; $display("FAIL cap_no_overwrite got=%b/%h exp=%b/%h", err_valid, err_addr, exp_v, exp_a); end
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL cap_clear got=%b exp=0", err_valid); end
    @(negedge clk);
    err_clr = 1'b1; priv[1] = 1'b0; chk_addr[1] = 32'h6000; chk_type[1] = R; chk_valid = 2'b10;
    @(posedge clk); #1;
    err_clr = 1'b0; chk_valid = 2'b00;
`ifdef PMP_ERR_CAPTURE_EN
    exp_a = 32'h6000;
`endif
    checks++; if ({err_valid, err_addr} !== {exp_v, exp_a}) begin failures++; $display("FAIL cap_clr_and_fault got=%b/%h exp=%b/%h", err_valid, err_addr, exp_v, exp_a); end
  endtask

  initial begin
    test_reset();
    test_tor();
    test_na4_napot();
    test_lock();
    test_reset_mid();
    test_backpressure();
    test_csr_same_cycle();
    test_parallel();
    test_err_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
